// File: rtl/key_pkg.sv
// Shared types and constants for the key conditioner.
// Optional feature macro: KEY_AUTOREPEAT_EN (auto-repeat press pulses while held).
package key_pkg;

  // Per-channel press state
  typedef enum logic [1:0] {
    KS_IDLE = 2'd0,  // debounced level 0
    KS_DOWN = 2'd1,  // level 1, counting towards long press
    KS_HELD = 2'd2   // long press already reported
  } key_state_e;

  // Default timing, in 1 kHz clock cycles (milliseconds)
  localparam int DEF_DEBOUNCE_MS = 20;
  localparam int DEF_HOLD_MS     = 1000;
  localparam int DEF_REPEAT_MS   = 250;

  // Per-channel outputs bundled for the lane array
  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic hold;
  } key_evt_t;

  // Counter width for a value range of max_val states; never below 1 bit
  function automatic int cnt_w(input int max_val);
    return (max_val <= 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/key_channel.sv
// One key lane: 2-flop synchronizer, debouncer, press/hold state machine.
// Optional feature macro: KEY_AUTOREPEAT_EN.
module key_channel
  import key_pkg::*;
#(
  parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS,
  parameter int HOLD_MS     = DEF_HOLD_MS,
  parameter int REPEAT_MS   = DEF_REPEAT_MS
) (
  input  logic     clk_1kHz,
  input  logic     rst,
  input  logic     key_raw,
  output key_evt_t evt
);

  localparam int DW = cnt_w(DEBOUNCE_MS + 1);
  localparam int HW = cnt_w(HOLD_MS);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_MS - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_MS - 1);

  logic [1:0]    sync_pipe;
  logic          s;
  logic [DW-1:0] deb_cnt;
  logic          level;
  logic          deb_done, rise, fall;

  key_state_e    state, state_nxt;
  logic [HW-1:0] hold_cnt, hold_nxt;
  logic          press_q, rel_q, hold_q;
  logic          press_nxt, rel_nxt, hold_p_nxt;

`ifdef KEY_AUTOREPEAT_EN
  localparam int RW = cnt_w(REPEAT_MS);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_MS - 1);
  logic [RW-1:0] rep_cnt, rep_nxt;
`endif

  assign s        = sync_pipe[1];
  // A level change is accepted on the DEBOUNCE_MS-th consecutive differing sample
  assign deb_done = (s != level) && (deb_cnt == DEB_LAST);
  assign rise     = deb_done & s;
  assign fall     = deb_done & ~s;

  // Synchronize the raw input and debounce it into the accepted level
  always_ff @(posedge clk_1kHz) begin
    if (rst) begin
      sync_pipe <= '0;
      deb_cnt   <= '0;
      level     <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[0], key_raw};
      if ((s == level) || deb_done) deb_cnt <= '0;
      else                          deb_cnt <= deb_cnt + 1'b1;
      if (deb_done) level <= s;
    end
  end

  // Next state and next pulses; pulses are registered so they line up with level
  always_comb begin
    state_nxt  = state;
    hold_nxt   = hold_cnt;
    press_nxt  = 1'b0;
    rel_nxt    = 1'b0;
    hold_p_nxt = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
    rep_nxt    = rep_cnt;
`endif
    case (state)
      KS_IDLE: begin
        if (rise) begin
          state_nxt = KS_DOWN;
          hold_nxt  = '0;
          press_nxt = 1'b1;
        end
      end
      KS_DOWN: begin
        if (fall) begin
          // release wins over a coincident hold expiry
          state_nxt = KS_IDLE;
          hold_nxt  = '0;
          rel_nxt   = 1'b1;
        end else if (hold_cnt == HOLD_LAST) begin
          state_nxt  = KS_HELD;
          hold_p_nxt = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
          rep_nxt    = '0;
`endif
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      KS_HELD: begin
        // hold_cnt stays saturated at HOLD_LAST here
        if (fall) begin
          state_nxt = KS_IDLE;
          hold_nxt  = '0;
          rel_nxt   = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
          rep_nxt   = '0;
`endif
        end
`ifdef KEY_AUTOREPEAT_EN
        else if (rep_cnt == REP_LAST) begin
          press_nxt = 1'b1;
          rep_nxt   = '0;
        end else begin
          rep_nxt = rep_cnt + 1'b1;
        end
`endif
      end
      default: begin
        state_nxt = KS_IDLE;
        hold_nxt  = '0;
      end
    endcase
  end

  // State, hold counter and pulse registers
  always_ff @(posedge clk_1kHz) begin
    if (rst) begin
      state    <= KS_IDLE;
      hold_cnt <= '0;
      press_q  <= 1'b0;
      rel_q    <= 1'b0;
      hold_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
      press_q  <= press_nxt;
      rel_q    <= rel_nxt;
      hold_q   <= hold_p_nxt;
    end
  end

`ifdef KEY_AUTOREPEAT_EN
  // Auto-repeat period counter, only meaningful in KS_HELD
  always_ff @(posedge clk_1kHz) begin
    if (rst) rep_cnt <= '0;
    else     rep_cnt <= rep_nxt;
  end
`endif

  assign evt.level = level;
  assign evt.press = press_q;
  assign evt.rel   = rel_q;
  assign evt.hold  = hold_q;

endmodule

// File: rtl/key_conditioner.sv
// Key conditioner top: N_KEYS independent key_channel lanes plus port bundling.
// Optional feature macro: KEY_AUTOREPEAT_EN (auto-repeat press pulses while held).
module key_conditioner
  import key_pkg::*;
#(
  parameter int N_KEYS      = 5,
  parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS,
  parameter int HOLD_MS     = DEF_HOLD_MS,
  parameter int REPEAT_MS   = DEF_REPEAT_MS
) (
  input  logic              clk_1kHz,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_hold
);

  // Illegal timing would break the counter compare points
  if (DEBOUNCE_MS < 1 || HOLD_MS < 2 || REPEAT_MS < 1) begin : g_bad_param
    $error("key_conditioner: illegal timing parameter");
  end

  key_evt_t [N_KEYS-1:0] evt;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_ch
    key_channel #(
      .DEBOUNCE_MS(DEBOUNCE_MS),
      .HOLD_MS    (HOLD_MS),
      .REPEAT_MS  (REPEAT_MS)
    ) u_ch (
      .clk_1kHz(clk_1kHz),
      .rst     (rst),
      .key_raw (key_raw[g]),
      .evt     (evt[g])
    );
    assign key_level[g]   = evt[g].level;
    assign key_press[g]   = evt[g].press;
    assign key_release[g] = evt[g].rel;
    assign key_hold[g]    = evt[g].hold;
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Directed bench for key_conditioner with default timing (20/1000/250).
// Drives and samples on the falling edge; DUT registers on the rising edge.
module tb_key_conditioner;
  localparam int N = 5;

  logic         clk_1kHz = 1'b0;
  logic         rst      = 1'b1;
  logic [N-1:0] key_raw  = '0;
  logic [N-1:0] key_level, key_press, key_release, key_hold;

  int errs   = 0;
  int checks = 0;

  always #5 clk_1kHz = ~clk_1kHz;

  key_conditioner #(
    .N_KEYS(N), .DEBOUNCE_MS(20), .HOLD_MS(1000), .REPEAT_MS(250)
  ) dut (
    .clk_1kHz   (clk_1kHz),
    .rst        (rst),
    .key_raw    (key_raw),
    .key_level  (key_level),
    .key_press  (key_press),
    .key_release(key_release),
    .key_hold   (key_hold)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_1kHz);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_level"},   key_level,   '0);
    chk({tag, "_press"},   key_press,   '0);
    chk({tag, "_release"}, key_release, '0);
    chk({tag, "_hold"},    key_hold,    '0);
  endtask

  initial begin
    logic [N-1:0] acc;
    int t, k, np, nh;
    int rep_pos[$];

    // reset
    step(3);
    chk_zero("rst");
    rst = 1'b0;

    // clean press on key 0: level and press at edge 22 after the step
    key_raw[0] = 1'b1;
    step(21);
    chk("p0_early_level", key_level, 5'b00000);
    chk("p0_early_press", key_press, 5'b00000);
    step(1);
    chk("p0_level", key_level, 5'b00001);
    chk("p0_press", key_press, 5'b00001);
    step(1);
    chk("p0_press_1cyc", key_press, 5'b00000);
    chk("p0_level_stay", key_level, 5'b00001);

    // bounce on key 1: 5 high / 5 low never reaches 20 stable samples
    acc = '0;
    for (int i = 0; i < 60; i++) begin
      key_raw[1] = ((i / 5) % 2 == 0);
      step(1);
      acc[1] = acc[1] | key_level[1] | key_press[1] | key_release[1];
    end
    key_raw[1] = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(1);
      acc[1] = acc[1] | key_level[1] | key_press[1] | key_release[1];
    end
    chk("bounce_k1", acc[1], 1'b0);
    chk("bounce_level", key_level, 5'b00001);

    // release key 0
    key_raw[0] = 1'b0;
    step(21);
    chk("r0_early", key_release, 5'b00000);
    step(1);
    chk("r0_release", key_release, 5'b00001);
    chk("r0_level", key_level, 5'b00000);
    step(1);
    chk("r0_release_1cyc", key_release, 5'b00000);

    // press then release key 2, no hold
    key_raw[2] = 1'b1;
    acc = '0;
    for (int i = 0; i < 22; i++) begin step(1); acc = acc | key_hold; end
    chk("p2_press", key_press, 5'b00100);
    for (int i = 0; i < 10; i++) begin step(1); acc = acc | key_hold; end
    key_raw[2] = 1'b0;
    for (int i = 0; i < 21; i++) begin step(1); acc = acc | key_hold; end
    chk("r2_early", key_release, 5'b00000);
    step(1);
    acc = acc | key_hold;
    chk("r2_release", key_release, 5'b00100);
    chk("r2_level", key_level, 5'b00000);
    chk("r2_no_hold", acc, 5'b00000);

    // long press on key 3
    key_raw[3] = 1'b1;
    t = 0;
    while (!key_press[3] && t < 40) begin step(1); t++; end
    chk("lp_press_lat", t, 22);
    k = 0; np = 0;
    while (!key_hold[3] && k < 1100) begin
      step(1); k++;
      if (key_press[3]) np++;
    end
    chk("lp_hold_lat", k, 1000);
    chk("lp_hold_only3", key_hold, 5'b01000);
    chk("lp_no_press_before_hold", np, 0);
    nh = 0;
    for (int j = 1; j <= 550; j++) begin
      step(1);
      if (key_press[3]) rep_pos.push_back(j);
      if (key_hold[3]) nh++;
    end
    chk("lp_hold_once", nh, 0);
`ifdef KEY_AUTOREPEAT_EN
    chk("lp_rep_count", rep_pos.size(), 2);
    chk("lp_rep0", (rep_pos.size() > 0) ? rep_pos[0] : -1, 250);
    chk("lp_rep1", (rep_pos.size() > 1) ? rep_pos[1] : -1, 500);
`else
    chk("lp_no_repeat", rep_pos.size(), 0);
`endif
    key_raw[3] = 1'b0;
    step(22);
    chk("lp_release", key_release, 5'b01000);
    chk("lp_level", key_level, 5'b00000);

    // keys 0 and 4 stepped together
    key_raw = 5'b10001;
    step(21);
    chk("sim_early", key_press, 5'b00000);
    step(1);
    chk("sim_press", key_press, 5'b10001);
    chk("sim_level", key_level, 5'b10001);
    step(999);
    chk("sim_hold_early", key_hold, 5'b00000);
    step(1);
    chk("sim_hold", key_hold, 5'b10001);
    step(5);

    // one-cycle reset while both keys are held
    rst = 1'b1;
    step(1);
    chk_zero("mid_rst");
    rst = 1'b0;
    acc = '0;
    for (int i = 0; i < 21; i++) begin step(1); acc = acc | key_release | key_press; end
    chk("post_rst_quiet", acc, 5'b00000);
    chk("post_rst_level0", key_level, 5'b00000);
    step(1);
    chk("post_rst_press", key_press, 5'b10001);
    chk("post_rst_release", key_release, 5'b00000);

    key_raw = '0;
    step(5);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
